// File: rtl/rr_datapath_sched_if.sv
// -----------------------------------------------------------------------------
// rr_datapath_sched_if
// Bundles the request, datapath and response signals of rr_datapath_sched.
//   sched_en     : 1 = grant and issue, 0 = stop granting and drain
//   req_valid    : per-requester request valid
//   req_data     : packed request data, requester i at [i*WIDTH +: WIDTH]
//   req_ready    : one-hot grant back to the requesters
//   dp_in_valid  : registered issue strobe to the datapath slot
//   dp_in_data   : registered issue data to the datapath slot
//   dp_out_data  : datapath result, valid DP_LATENCY cycles after dp_in_valid
//   rsp_valid    : registered response strobe (no backpressure)
//   rsp_id       : requester ID of the response
//   rsp_data     : response data
//   idle         : scheduler idle, nothing in flight
//   issued_cnt   : total issues since reset (wraps)
// Modports: slave = scheduler view, master = stimulus/datapath view.
// -----------------------------------------------------------------------------
interface rr_datapath_sched_if #(
  parameter int N_REQ = 4,
  parameter int WIDTH = 32,
  parameter int ID_W  = $clog2(N_REQ)
);
  logic                   sched_en;
  logic [N_REQ-1:0]       req_valid;
  logic [N_REQ*WIDTH-1:0] req_data;
  logic [N_REQ-1:0]       req_ready;
  logic                   dp_in_valid;
  logic [WIDTH-1:0]       dp_in_data;
  logic [WIDTH-1:0]       dp_out_data;
  logic                   rsp_valid;
  logic [ID_W-1:0]        rsp_id;
  logic [WIDTH-1:0]       rsp_data;
  logic                   idle;
  logic [31:0]            issued_cnt;

  modport slave (
    input  sched_en, req_valid, req_data, dp_out_data,
    output req_ready, dp_in_valid, dp_in_data, rsp_valid, rsp_id, rsp_data,
           idle, issued_cnt
  );

  modport master (
    output sched_en, req_valid, req_data, dp_out_data,
    input  req_ready, dp_in_valid, dp_in_data, rsp_valid, rsp_id, rsp_data,
           idle, issued_cnt
  );
endinterface

// File: rtl/rr_datapath_sched.sv
// -----------------------------------------------------------------------------
// rr_datapath_sched
// Round-robin scheduler sharing one fixed-latency datapath slot among N_REQ
// requesters. At most one grant per cycle; the granted word is registered into
// the datapath, its requester ID rides a tag pipe of DP_LATENCY stages, and the
// datapath result is returned with that ID. sched_en low stops granting and
// lets in-flight words drain before the FSM reports idle.
// Ports:
//   clk  : clock, rising edge
//   rst  : asynchronous active-high reset
//   bus  : rr_datapath_sched_if.slave (request, datapath, response, status)
// -----------------------------------------------------------------------------
module rr_datapath_sched #(
  parameter int N_REQ      = 4,
  parameter int WIDTH      = 32,
  parameter int DP_LATENCY = 3,
  parameter int ID_W       = $clog2(N_REQ)
) (
  input  logic                clk,
  input  logic                rst,
  rr_datapath_sched_if.slave  bus
);

  // Must hold DP_LATENCY+2 outstanding words.
  localparam int CNT_W = $clog2(DP_LATENCY + 3);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

  state_t           state, state_nxt;
  logic [ID_W-1:0]  ptr;
  logic [N_REQ-1:0] gnt;
  logic [ID_W-1:0]  gnt_id;
  logic             gnt_any;
  logic [CNT_W-1:0] inflight, inflight_nxt;

  logic             iss_vld_p0;
  logic [WIDTH-1:0] iss_data_p0;
  logic [ID_W-1:0]  iss_id_p0;
  logic [31:0]      issued;

  logic             tag_vld_p1 [DP_LATENCY];
  logic [ID_W-1:0]  tag_id_p1  [DP_LATENCY];

  logic             rsp_vld_p2;
  logic [ID_W-1:0]  rsp_id_p2;
  logic [WIDTH-1:0] rsp_data_p2;

  function automatic logic [ID_W-1:0] next_ptr(input logic [ID_W-1:0] id);
    if (id == ID_W'(N_REQ - 1)) return '0;
    return id + ID_W'(1);
  endfunction

  // Rotating priority search starting at ptr. Gated by sched_en so that the
  // cycle leaving RUN never carries a transfer.
  always_comb begin
    logic [ID_W:0]   idx_full;
    logic [ID_W-1:0] idx;
    gnt      = '0;
    gnt_id   = '0;
    gnt_any  = 1'b0;
    idx_full = '0;
    idx      = '0;
    if (state == S_RUN && bus.sched_en) begin
      for (int k = 0; k < N_REQ; k++) begin
        idx_full = {1'b0, ptr} + (ID_W+1)'(k);
        if (idx_full >= (ID_W+1)'(N_REQ)) idx_full = idx_full - (ID_W+1)'(N_REQ);
        idx = idx_full[ID_W-1:0];
        if (!gnt_any && bus.req_valid[idx]) begin
          gnt[idx] = 1'b1;
          gnt_id   = idx;
          gnt_any  = 1'b1;
        end
      end
    end
  end

  always_comb begin
    inflight_nxt = inflight;
    case ({gnt_any, rsp_vld_p2})
      2'b10:   inflight_nxt = inflight + CNT_W'(1);
      2'b01:   inflight_nxt = inflight - CNT_W'(1);
      default: inflight_nxt = inflight;
    endcase
  end

  // Looking at the post-update count lets idle rise the cycle right after the
  // last response instead of one cycle later.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (bus.sched_en) state_nxt = S_RUN;
      S_RUN:   if (!bus.sched_en)
                 state_nxt = (inflight_nxt == '0) ? S_IDLE : S_DRAIN;
      S_DRAIN: if (inflight_nxt == '0) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      inflight <= '0;
    end else begin
      state    <= state_nxt;
      inflight <= inflight_nxt;
    end
  end

  // ---- stage p0: issue register into the datapath ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      iss_vld_p0  <= 1'b0;
      iss_data_p0 <= '0;
      iss_id_p0   <= '0;
      ptr         <= '0;
      issued      <= '0;
    end else begin
      iss_vld_p0 <= gnt_any;
      if (gnt_any) begin
        iss_data_p0 <= bus.req_data[int'(gnt_id)*WIDTH +: WIDTH];
        iss_id_p0   <= gnt_id;
        ptr         <= next_ptr(gnt_id);
        issued      <= issued + 32'd1;
      end
    end
  end

  // ---- stage p1: tag pipe tracking the datapath latency ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < DP_LATENCY; k++) begin
        tag_vld_p1[k] <= 1'b0;
        tag_id_p1[k]  <= '0;
      end
    end else begin
      tag_vld_p1[0] <= iss_vld_p0;
      tag_id_p1[0]  <= iss_id_p0;
      for (int k = 1; k < DP_LATENCY; k++) begin
        tag_vld_p1[k] <= tag_vld_p1[k-1];
        tag_id_p1[k]  <= tag_id_p1[k-1];
      end
    end
  end

  // ---- stage p2: response register ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_vld_p2  <= 1'b0;
      rsp_id_p2   <= '0;
      rsp_data_p2 <= '0;
    end else begin
      rsp_vld_p2 <= tag_vld_p1[DP_LATENCY-1];
      if (tag_vld_p1[DP_LATENCY-1]) begin
        rsp_id_p2   <= tag_id_p1[DP_LATENCY-1];
        rsp_data_p2 <= bus.dp_out_data;
      end
    end
  end

  assign bus.req_ready   = gnt;
  assign bus.dp_in_valid = iss_vld_p0;
  assign bus.dp_in_data  = iss_data_p0;
  assign bus.rsp_valid   = rsp_vld_p2;
  assign bus.rsp_id      = rsp_id_p2;
  assign bus.rsp_data    = rsp_data_p2;
  assign bus.idle        = (state == S_IDLE);
  assign bus.issued_cnt  = issued;

endmodule

// File: tb/tb_rr_datapath_sched.sv
// -----------------------------------------------------------------------------
// tb_rr_datapath_sched
// Bench for rr_datapath_sched with N_REQ=4, DP_LATENCY=3 and a datapath model
// returning dp_in+1 three cycles later. Grant vectors come from a table; the
// responses are tracked by a scoreboard queue with their due cycle.
// -----------------------------------------------------------------------------
module tb_rr_datapath_sched;
  localparam int N_REQ = 4;
  localparam int WIDTH = 32;
  localparam int DPL   = 3;
  localparam int ID_W  = 2;

  typedef struct {
    logic       se;
    logic [3:0] valid;
    logic [3:0] exp_ready;
  } vec_t;

  typedef struct {
    logic [ID_W-1:0]  id;
    logic [WIDTH-1:0] data;
    int               due;
  } sb_t;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;
  sb_t  sb [$];

  logic             prev_g = 1'b0;
  logic [WIDTH-1:0] prev_d = '0;
  logic [31:0]      exp_issued = '0;
  logic             s_rsp, s_idle;
  logic [WIDTH-1:0] dpq [DPL];

  rr_datapath_sched_if #(.N_REQ(N_REQ), .WIDTH(WIDTH), .ID_W(ID_W)) bus ();

  rr_datapath_sched #(.N_REQ(N_REQ), .WIDTH(WIDTH), .DP_LATENCY(DPL), .ID_W(ID_W))
    dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Datapath model: result = input + 1, DPL cycles later.
  always @(posedge clk) begin
    dpq[0] <= bus.dp_in_data + 32'd1;
    for (int k = 1; k < DPL; k++) dpq[k] <= dpq[k-1];
  end
  assign bus.dp_out_data = dpq[DPL-1];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [ID_W-1:0] onehot_id(input logic [3:0] oh);
    logic [ID_W-1:0] r = '0;
    for (int i = 0; i < N_REQ; i++) if (oh[i]) r = ID_W'(i);
    return r;
  endfunction

  function automatic logic [WIDTH-1:0] get_data(input logic [ID_W-1:0] id);
    return bus.req_data[int'(id)*WIDTH +: WIDTH];
  endfunction

  task automatic set_data(input int i, input logic [WIDTH-1:0] d);
    bus.req_data[i*WIDTH +: WIDTH] = d;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_req_ready"},   32'(bus.req_ready),   32'h0);
    check({tag, "_dp_in_valid"}, 32'(bus.dp_in_valid), 32'h0);
    check({tag, "_dp_in_data"},  bus.dp_in_data,       32'h0);
    check({tag, "_rsp_valid"},   32'(bus.rsp_valid),   32'h0);
    check({tag, "_rsp_id"},      32'(bus.rsp_id),      32'h0);
    check({tag, "_rsp_data"},    bus.rsp_data,         32'h0);
    check({tag, "_idle"},        32'(bus.idle),        32'h1);
    check({tag, "_issued_cnt"},  bus.issued_cnt,       32'h0);
  endtask

  // One cycle: drive inputs just after the edge, check at the falling edge.
  task automatic apply_row(input logic se, input logic [3:0] v, input logic [3:0] exp);
    sb_t e;
    bus.sched_en  = se;
    bus.req_valid = v;
    @(negedge clk);
    s_rsp  = bus.rsp_valid;
    s_idle = bus.idle;
    check("req_ready",   32'(bus.req_ready),   32'(exp));
    check("dp_in_valid", 32'(bus.dp_in_valid), 32'(prev_g));
    if (prev_g) check("dp_in_data", bus.dp_in_data, prev_d);
    check("issued_cnt", bus.issued_cnt, exp_issued);
    prev_g = (exp != 4'h0);
    if (prev_g) begin
      e.id   = onehot_id(exp);
      e.data = get_data(e.id) + 32'd1;
      e.due  = cyc + DPL + 2;
      sb.push_back(e);
      prev_d = get_data(e.id);
      exp_issued++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic wait_sb_empty(input string name);
    for (int k = 0; k < 12 && sb.size() > 0; k++) apply_row(1'b1, 4'h0, 4'h0);
    check(name, 32'(sb.size()), 32'h0);
  endtask

  // Response scoreboard.
  always @(negedge clk) begin
    sb_t e;
    if (sb.size() > 0 && cyc > sb[0].due) begin
      n_tests++;
      n_fail++;
      $display("FAIL rsp_missing: id %0d not seen by cycle %0d (now %0d)", sb[0].id, sb[0].due, cyc);
      void'(sb.pop_front());
    end
    if (bus.rsp_valid) begin
      if (sb.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL rsp_unexpected: id %0d data 0x%0h, expected none", bus.rsp_id, bus.rsp_data);
      end else begin
        e = sb.pop_front();
        check("rsp_id",    32'(bus.rsp_id), 32'(e.id));
        check("rsp_data",  bus.rsp_data,    e.data);
        check("rsp_cycle", 32'(cyc),        32'(e.due));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vec_t tbl [14];
    int   n;
    logic done;

    // Grant table; pointer is 2 on entry (after the single request to 1).
    tbl[0]  = '{1'b1, 4'b1000, 4'b1000};
    for (int i = 0; i < 8; i++) tbl[1+i] = '{1'b1, 4'b1111, 4'(1 << (i % 4))};
    tbl[9]  = '{1'b1, 4'b0100, 4'b0100};
    tbl[10] = '{1'b1, 4'b0101, 4'b0001};
    tbl[11] = '{1'b1, 4'b0101, 4'b0100};
    tbl[12] = '{1'b1, 4'b0000, 4'b0000};
    tbl[13] = '{1'b1, 4'b0011, 4'b0001};

    rst           = 1'b1;
    bus.sched_en  = 1'b0;
    bus.req_valid = '0;
    for (int i = 0; i < N_REQ; i++) set_data(i, 32'(32'h100 * i));
    #1;
    check_reset_vals("por");
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Disabled: requests present but no grants while sched_en is low.
    for (int k = 0; k < 3; k++) begin
      apply_row(1'b0, 4'b1111, 4'b0000);
      check("disabled_idle", 32'(s_idle), 32'h1);
    end

    // Single request (first row moves IDLE -> RUN).
    apply_row(1'b1, 4'b0000, 4'b0000);
    set_data(1, 32'h10);
    apply_row(1'b1, 4'b0010, 4'b0010);
    wait_sb_empty("single_drained");
    set_data(1, 32'h100);

    // Round-robin sequence and wrap priority.
    for (int i = 0; i < 14; i++) apply_row(tbl[i].se, tbl[i].valid, tbl[i].exp_ready);
    wait_sb_empty("table_drained");

    // Drain: three issues, disable, then sched_en back high is ignored in DRAIN.
    apply_row(1'b1, 4'b1111, 4'b0010);
    apply_row(1'b1, 4'b1111, 4'b0100);
    apply_row(1'b1, 4'b1111, 4'b1000);
    apply_row(1'b0, 4'b1111, 4'b0000);
    check("drain_start_idle", 32'(s_idle), 32'h0);
    n = 0;
    done = 1'b0;
    for (int k = 0; k < 15 && !done; k++) begin
      apply_row(1'b1, 4'b1111, 4'b0000);
      check("drain_busy_idle", 32'(s_idle), 32'h0);
      if (s_rsp) n++;
      if (n == 3) begin
        apply_row(1'b1, 4'b1111, 4'b0000);
        check("drain_done_idle", 32'(s_idle), 32'h1);
        done = 1'b1;
      end
    end
    if (!done) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain_timeout: got %0d responses, required 3", n);
    end
    apply_row(1'b0, 4'b0000, 4'b0000);
    apply_row(1'b0, 4'b0000, 4'b0000);

    // Reset with two words in flight.
    apply_row(1'b1, 4'b0000, 4'b0000);
    apply_row(1'b1, 4'b1111, 4'b0001);
    apply_row(1'b1, 4'b1111, 4'b0010);
    bus.sched_en  = 1'b0;
    bus.req_valid = '0;
    #1;
    rst = 1'b1;
    #1;
    check_reset_vals("midrst");
    sb.delete();
    prev_g     = 1'b0;
    exp_issued = '0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int k = 0; k < 10; k++) begin
      apply_row(1'b0, 4'b0000, 4'b0000);
      check("postrst_rsp_valid", 32'(s_rsp), 32'h0);
      check("postrst_idle", 32'(s_idle), 32'h1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
